// File: rtl/pixel_to_gray_conv.sv
// rtl/pixel_to_gray_conv.sv - multi-format (gray/YUV422/RGB888) to luma converter, 2-stage AXIS pipeline
// Optional statistics counters enabled by defining PIX2GRAY_STATS_EN.
module pixel_to_gray_conv #(
  parameter int DATA_WIDTH = 8,
  parameter int PPC        = 4,
  parameter bit YUV_Y_DEF  = 1'b0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [1:0]                     cfg_mode,
  input  logic                           cfg_y_sel,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [3*DATA_WIDTH*PPC-1:0]    s_axis_tdata,
  input  logic                           s_axis_tuser,
  input  logic                           s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [DATA_WIDTH*PPC-1:0]      m_axis_tdata,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic [1:0]                     active_mode
`ifdef PIX2GRAY_STATS_EN
  ,
  output logic [15:0]                    stat_frame_cnt,
  output logic [15:0]                    stat_line_cnt
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = DATA_WIDTH + 8;

  logic adv1, adv2, in_hs, sof_hs;
  logic [1:0] mode_q, cur_mode;
  logic ysel_q, cur_ysel;

  logic [PPC-1:0][DW-1:0] c0, c1, c2;
  logic [PPC-1:0][AW-1:0] n_pr, n_pg, n_pb;
  logic [PPC-1:0][DW-1:0] n_sel;

  logic                   v1, s1_rgb, s1_user, s1_last;
  logic [PPC-1:0][AW-1:0] s1_pr, s1_pg, s1_pb;
  logic [PPC-1:0][DW-1:0] s1_sel;
  logic [PPC-1:0][DW-1:0] n_y;

  assign adv2          = !m_axis_tvalid || m_axis_tready;
  assign adv1          = !v1 || adv2;
  assign s_axis_tready = adv1;
  assign in_hs         = s_axis_tvalid && adv1;
  assign sof_hs        = in_hs && s_axis_tuser;

  // The start-of-frame beat itself already uses the incoming configuration.
  assign cur_mode    = sof_hs ? cfg_mode  : mode_q;
  assign cur_ysel    = sof_hs ? cfg_y_sel : ysel_q;
  assign active_mode = mode_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mode_q <= 2'b01;
      ysel_q <= YUV_Y_DEF;
    end else if (sof_hs) begin
      mode_q <= cfg_mode;
      ysel_q <= cfg_y_sel;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PPC; gi++) begin : g_lane
      assign c0[gi] = s_axis_tdata[3*DW*gi        +: DW];
      assign c1[gi] = s_axis_tdata[3*DW*gi + DW   +: DW];
      assign c2[gi] = s_axis_tdata[3*DW*gi + 2*DW +: DW];
    end
  endgenerate

  always_comb begin
    n_pr  = '0;
    n_pg  = '0;
    n_pb  = '0;
    n_sel = '0;
    for (int i = 0; i < PPC; i++) begin
      n_pr[i]  = AW'(c0[i]) * AW'(77);
      n_pg[i]  = AW'(c1[i]) * AW'(150);
      n_pb[i]  = AW'(c2[i]) * AW'(29);
      n_sel[i] = (cur_mode == 2'b01 && cur_ysel) ? c1[i] : c0[i];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v1      <= 1'b0;
      s1_rgb  <= 1'b0;
      s1_user <= 1'b0;
      s1_last <= 1'b0;
      s1_pr   <= '0;
      s1_pg   <= '0;
      s1_pb   <= '0;
      s1_sel  <= '0;
    end else if (adv1) begin
      v1 <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        s1_rgb  <= (cur_mode == 2'b10);
        s1_user <= s_axis_tuser;
        s1_last <= s_axis_tlast;
        s1_pr   <= n_pr;
        s1_pg   <= n_pg;
        s1_pb   <= n_pb;
        s1_sel  <= n_sel;
      end
    end
  end

  // Weights sum to 256, so the rounded sum always fits in DW bits after the shift.
  always_comb begin
    n_y = '0;
    for (int i = 0; i < PPC; i++) begin
      logic [AW-1:0] acc;
      acc    = s1_pr[i] + s1_pg[i] + s1_pb[i] + AW'(128);
      n_y[i] = s1_rgb ? acc[AW-1:8] : s1_sel[i];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (adv2) begin
      m_axis_tvalid <= v1;
      if (v1) begin
        m_axis_tdata <= n_y;
        m_axis_tuser <= s1_user;
        m_axis_tlast <= s1_last;
      end
    end
  end

`ifdef PIX2GRAY_STATS_EN
  logic out_hs;
  assign out_hs = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_frame_cnt <= '0;
      stat_line_cnt  <= '0;
    end else if (out_hs) begin
      if (m_axis_tuser) begin
        stat_frame_cnt <= stat_frame_cnt + 16'd1;
        stat_line_cnt  <= {15'd0, m_axis_tlast};
      end else if (m_axis_tlast) begin
        stat_line_cnt  <= stat_line_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_to_gray_conv.sv
// tb/tb_pixel_to_gray_conv.sv - directed and random-backpressure checks for pixel_to_gray_conv
module tb_pixel_to_gray_conv;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [1:0]  cfg_mode = 2'b00;
  logic        cfg_y_sel = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [95:0] s_axis_tdata = '0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [1:0]  active_mode;
`ifdef PIX2GRAY_STATS_EN
  logic [15:0] stat_frame_cnt;
  logic [15:0] stat_line_cnt;
`endif

  logic m_rand = 1'b0;
  logic m_ready_fix = 1'b1;
  logic rnd_bit = 1'b0;
  assign m_axis_tready = m_rand ? rnd_bit : m_ready_fix;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cycles = 0;
  int rx_count = 0;
  logic [33:0] exp_q[$];

  pixel_to_gray_conv #(.DATA_WIDTH(8), .PPC(4), .YUV_Y_DEF(1'b0)) dut (
    .aclk(aclk), .areset(areset), .cfg_mode(cfg_mode), .cfg_y_sel(cfg_y_sel),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .active_mode(active_mode)
`ifdef PIX2GRAY_STATS_EN
    , .stat_frame_cnt(stat_frame_cnt), .stat_line_cnt(stat_line_cnt)
`endif
  );

  always #5 aclk = ~aclk;
  always @(negedge aclk) rnd_bit = 1'($urandom_range(0, 1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] gray_of(input logic [95:0] d, input logic [1:0] m, input logic ys);
    logic [31:0] o;
    int r, g, b, y;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      r = int'(d[24*i +: 8]);
      g = int'(d[24*i+8 +: 8]);
      b = int'(d[24*i+16 +: 8]);
      if (m == 2'b10)      y = (77*r + 150*g + 29*b + 128) / 256;
      else if (m == 2'b01) y = ys ? g : r;
      else                 y = r;
      o[8*i +: 8] = y[7:0];
    end
    return o;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [95:0] d, input logic u, input logic l, input logic [31:0] e);
    int n;
    logic hs;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    hs = 1'b0;
    while (!hs && n < 200) begin
      #4;
      hs = s_axis_tready;
      if (hs) exp_q.push_back({u, l, e});
      else stall_cycles++;
      @(negedge aclk);
      n++;
    end
    if (!hs) check("send_timeout", 64'(n), 0);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge aclk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 0);
  endtask

  logic        prev_stall = 1'b0;
  logic [33:0] prev_beat = '0;
  always begin
    @(negedge aclk);
    #4;
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_axis_tvalid), 1);
        check("hold_beat", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(prev_beat));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        rx_count++;
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else check("beat", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] d_rgb, d_yuv, d;
    logic [1:0]  fm;
    logic        fy;
    int          rx0;
    d_rgb = {24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
    d_yuv = {4{24'h008010}};

    repeat (3) @(negedge aclk);
    check("rst_tvalid", 64'(m_axis_tvalid), 0);
    check("rst_tdata", 64'(m_axis_tdata), 0);
    check("rst_tuser_tlast", 64'({m_axis_tuser, m_axis_tlast}), 0);
    check("rst_active_mode", 64'(active_mode), 64'd1);
    areset = 1'b0;
    @(negedge aclk);
    check("rst_tready", 64'(s_axis_tready), 1);

    cfg_mode = 2'b10;
    send(d_rgb, 1'b1, 1'b1, {8'd29, 8'd149, 8'd77, 8'd255});
    drain();
    check("mode_rgb", 64'(active_mode), 64'd2);

    cfg_mode = 2'b01; cfg_y_sel = 1'b0;
    send(d_yuv, 1'b1, 1'b1, 32'h10101010);
    cfg_y_sel = 1'b1;
    send(d_yuv, 1'b1, 1'b1, 32'h80808080);
    drain();

    cfg_mode = 2'b10;
    send(d_rgb, 1'b1, 1'b0, {8'd29, 8'd149, 8'd77, 8'd255});
    cfg_mode = 2'b01; cfg_y_sel = 1'b1;
    send(d_rgb, 1'b0, 1'b1, {8'd29, 8'd149, 8'd77, 8'd255});
    drain();
    check("midframe_mode_held", 64'(active_mode), 64'd2);
    send(d_rgb, 1'b1, 1'b1, 32'h00FF00FF);
    check("mode_update_on_sof", 64'(active_mode), 64'd1);

    cfg_mode = 2'b00;
    send(d_rgb, 1'b1, 1'b1, 32'h0000FFFF);
    cfg_mode = 2'b11;
    send(d_rgb, 1'b1, 1'b1, 32'h0000FFFF);
    drain();
    check("mode_reserved", 64'(active_mode), 64'd3);

    stall_cycles = 0;
    cfg_mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom};
      send(d, i == 0, i == 7, gray_of(d, 2'b10, 1'b0));
    end
    check("throughput_stalls", 64'(stall_cycles), 0);
    drain();

    m_rand = 1'b1;
    rx0 = rx_count;
    for (int f = 0; f < 20; f++) begin
      fm = 2'($urandom_range(0, 3));
      fy = 1'($urandom_range(0, 1));
      for (int ln = 0; ln < 10; ln++) begin
        for (int bt = 0; bt < 5; bt++) begin
          if ($urandom_range(0, 3) == 0) @(negedge aclk);
          if (ln == 0 && bt == 0) begin
            cfg_mode = fm; cfg_y_sel = fy;
          end else begin
            cfg_mode = 2'($urandom_range(0, 3)); cfg_y_sel = 1'($urandom_range(0, 1));
          end
          d = {$urandom, $urandom, $urandom};
          send(d, ln == 0 && bt == 0, bt == 4, gray_of(d, fm, fy));
        end
      end
    end
    drain();
    check("random_beat_count", 64'(rx_count - rx0), 64'd1000);
    m_rand = 1'b0;

    m_ready_fix = 1'b0;
    cfg_mode = 2'b10;
    send(d_rgb, 1'b1, 1'b0, 32'h0);
    send(d_rgb, 1'b0, 1'b0, 32'h0);
    areset = 1'b1;
    #1;
    check("reset_flush_tvalid", 64'(m_axis_tvalid), 0);
    check("reset_active_mode", 64'(active_mode), 64'd1);
    exp_q.delete();
    @(negedge aclk);
    areset = 1'b0;
    m_ready_fix = 1'b1;
    rx0 = rx_count;
    repeat (10) @(negedge aclk);
    check("no_stale_beat", 64'(rx_count - rx0), 0);

`ifdef PIX2GRAY_STATS_EN
    cfg_mode = 2'b00;
    for (int f = 0; f < 3; f++)
      for (int ln = 0; ln < 4; ln++)
        send(96'h0, ln == 0, 1'b1, 32'h0);
    drain();
    check("stat_frame_cnt", 64'(stat_frame_cnt), 64'd3);
    check("stat_line_cnt", 64'(stat_line_cnt), 64'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
